reg_msg_scheduler: RTL and testbench



---
 rtl/reg_msg_scheduler_if.sv | 24 ++
 rtl/reg_msg_scheduler.sv | 111 +++++++++++
 tb/tb_reg_msg_scheduler.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_msg_scheduler_if.sv
// rtl/reg_msg_scheduler_if.sv - register-block and host TX link signals of the read-side scheduler
`timescale 1ns/1ps
interface reg_msg_scheduler_if #(parameter int N = 28);
    logic         enable;
    logic [N-1:0] have_msg_bus;
    logic [7:0]   len;
    logic [7:0]   slave_data;
    logic [N-1:0] grant_bus;
    logic [N-1:0] rdreq_bus;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;

    modport master (
        input  enable, have_msg_bus, len, slave_data, tx_ready,
        output grant_bus, rdreq_bus, tx_data, tx_valid, busy
    );

    modport slave (
        output enable, have_msg_bus, len, slave_data, tx_ready,
        input  grant_bus, rdreq_bus, tx_data, tx_valid, busy
    );
endinterface

// File: rtl/reg_msg_scheduler.sv
// rtl/reg_msg_scheduler.sv - round-robin read scheduler framing SYNC/ADDR/LEN/DATA/CHK packets
`timescale 1ns/1ps
module reg_msg_scheduler #(
    parameter int         N         = 28,
    parameter logic [7:0] SYNC_BYTE = 8'h55
) (
    input logic               clk,
    input logic               n_rst,
    reg_msg_scheduler_if.master sif
);
    localparam int IW = $clog2(N);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ADDR, S_LEN, S_DATA, S_CHK} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] rr_ptr, grant_idx, pick_idx;
    logic          pick_found;
    logic [IW:0]   scan;
    logic [N-1:0]  grant_q;
    logic [7:0]    checksum, count;

    // Scan downward so the lowest offset from rr_ptr is the one that sticks.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            scan = {1'b0, rr_ptr} + (IW + 1)'(k);
            if (scan >= (IW + 1)'(N))
                scan = scan - (IW + 1)'(N);
            if (sif.have_msg_bus[scan[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (sif.enable && pick_found) state_nxt = S_SYNC;
            S_SYNC: if (sif.tx_ready) state_nxt = S_ADDR;
            S_ADDR: if (sif.tx_ready) state_nxt = S_LEN;
            S_LEN:  if (sif.tx_ready) state_nxt = (sif.len != 8'd0) ? S_DATA : S_CHK;
            S_DATA: if (sif.tx_ready && count == 8'd1) state_nxt = S_CHK;
            S_CHK:  if (sif.tx_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rr_ptr    <= '0;
            grant_idx <= '0;
            grant_q   <= '0;
            checksum  <= '0;
            count     <= '0;
        end else begin
            case (state)
                S_IDLE: if (sif.enable && pick_found) begin
                    grant_idx <= pick_idx;
                    grant_q   <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
                end
                S_ADDR: checksum <= 8'(grant_idx);
                // len is captured once; later changes on the source are ignored.
                S_LEN: if (sif.tx_ready) begin
                    count    <= sif.len;
                    checksum <= checksum ^ sif.len;
                end
                S_DATA: if (sif.tx_ready) begin
                    count    <= count - 8'd1;
                    checksum <= checksum ^ sif.slave_data;
                end
                S_CHK: if (sif.tx_ready) begin
                    rr_ptr  <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
                    grant_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // DATA bytes flow straight from the source so the pop lines up with the accepted byte.
    always_comb begin
        sif.tx_valid  = 1'b0;
        sif.tx_data   = 8'd0;
        sif.rdreq_bus = '0;
        sif.busy      = (state != S_IDLE);
        case (state)
            S_SYNC: begin sif.tx_valid = 1'b1; sif.tx_data = SYNC_BYTE;       end
            S_ADDR: begin sif.tx_valid = 1'b1; sif.tx_data = 8'(grant_idx);   end
            S_LEN:  begin sif.tx_valid = 1'b1; sif.tx_data = sif.len;         end
            S_DATA: begin
                sif.tx_valid  = 1'b1;
                sif.tx_data   = sif.slave_data;
                sif.rdreq_bus = sif.tx_ready ? grant_q : '0;
            end
            S_CHK:  begin sif.tx_valid = 1'b1; sif.tx_data = checksum;        end
            default: ;
        endcase
    end

    assign sif.grant_bus = grant_q;
endmodule

// File: tb/tb_reg_msg_scheduler.sv
// tb/tb_reg_msg_scheduler.sv - bench for reg_msg_scheduler against a packet-level reference model
`timescale 1ns/1ps
module tb_reg_msg_scheduler;
    localparam int N = 28;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    reg_msg_scheduler_if #(.N(N)) bus();
    reg_msg_scheduler #(.N(N), .SYNC_BYTE(8'h55)) dut (.clk(clk), .n_rst(n_rst), .sif(bus));

    int checks = 0;
    int errors = 0;

    // Register-block emulation: per-address byte arrays, popped by rdreq.
    logic [7:0] mem [N][16];
    int         len_tab [N];
    bit         len_glitch = 1'b0;
    int         rd_idx;
    int         gi;

    always_comb begin
        gi = 0;
        for (int i = 0; i < N; i++)
            if (bus.grant_bus[i]) gi = i;
        bus.len        = 8'(len_tab[gi]) ^ ((len_glitch && rd_idx > 0) ? 8'hFF : 8'h00);
        bus.slave_data = mem[gi][rd_idx[3:0]];
    end

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst)                  rd_idx <= 0;
        else if (bus.grant_bus == 0) rd_idx <= 0;
        else if (bus.rdreq_bus != 0) rd_idx <= rd_idx + 1;
    end

    // Link monitor: collects accepted bytes and rdreq pops, flags protocol breaches.
    logic [7:0] rx_q [$];
    int         rdreq_q [$];
    int         gap_bad = 0, hold_bad = 0, rdreq_bad = 0;
    bit         saw_idle = 1'b1, prev_stall = 1'b0;
    logic [7:0] prev_data;
    int         p_pos = 0, p_len = 0;

    always @(negedge clk) begin
        if (!n_rst) begin
            p_pos = 0; saw_idle = 1'b1; prev_stall = 1'b0;
        end else begin
            if (!bus.busy) saw_idle = 1'b1;
            if (prev_stall && (!bus.tx_valid || bus.tx_data !== prev_data)) hold_bad++;
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
            if (bus.rdreq_bus != 0) begin
                if ($countones(bus.rdreq_bus) != 1 || (bus.rdreq_bus & ~bus.grant_bus) != 0
                    || !(bus.tx_valid && bus.tx_ready)) rdreq_bad++;
                for (int i = 0; i < N; i++) if (bus.rdreq_bus[i]) rdreq_q.push_back(i);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                rx_q.push_back(bus.tx_data);
                if (p_pos == 0) begin
                    if (!saw_idle) gap_bad++;
                    saw_idle = 1'b0;
                end
                if (p_pos == 2) p_len = int'(bus.tx_data);
                p_pos++;
                if (p_pos >= 3 && p_pos == 4 + p_len) p_pos = 0;
            end
        end
    end

    // Reference model: expected byte stream and pop sequence from the packet rules.
    logic [7:0] exp_q [$];
    int         exp_rd [$];
    int         model_ptr = 0;
    int         rx_base, rd_base;

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        int i;
        for (int k = 0; k < N; k++) begin
            i = (ptr + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_pkt(input int a);
        logic [7:0] c;
        int l;
        l = len_tab[a];
        c = 8'(a) ^ 8'(l);
        exp_q.push_back(8'h55); exp_q.push_back(8'(a)); exp_q.push_back(8'(l));
        for (int k = 0; k < l; k++) begin
            exp_q.push_back(mem[a][k]);
            c = c ^ mem[a][k];
            exp_rd.push_back(a);
        end
        exp_q.push_back(c);
        model_ptr = (a + 1) % N;
    endtask

    task automatic model_serve(input logic [N-1:0] req, input int cnt);
        for (int p = 0; p < cnt; p++) model_pkt(rr_pick(req, model_ptr));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stimulus helpers
    bit           rand_ready = 1'b0;
    int           grants = 0, stop_after = 0, grant_cycles = 0;
    logic [N-1:0] prev_grant = '0, watch_grant = '1;

    task automatic step();
        @(posedge clk); #1;
        if (bus.grant_bus != 0 && prev_grant == 0) begin
            grants++;
            if (grants == stop_after) bus.enable = 1'b0;
        end
        prev_grant = bus.grant_bus;
        if (bus.grant_bus == watch_grant) grant_cycles++;
        if (rand_ready) bus.tx_ready = ($urandom_range(3) != 0);
    endtask

    task automatic start_test();
        rx_base = rx_q.size(); rd_base = rdreq_q.size();
        exp_q.delete(); exp_rd.delete();
        grants = 0; stop_after = 0; prev_grant = '0;
    endtask

    task automatic run(input string tag, input int budget);
        int n = 0;
        while (!(bus.busy == 1'b0 && rx_q.size() - rx_base >= exp_q.size()) && n < budget) begin
            step(); n++;
        end
        check($sformatf("%s_timeout", tag), 32'(n < budget), 32'd1);
    endtask

    task automatic compare(input string tag);
        check($sformatf("%s_nbytes", tag), 32'(rx_q.size() - rx_base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && rx_base + i < rx_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[rx_base + i]), 32'(exp_q[i]));
        check($sformatf("%s_npop", tag), 32'(rdreq_q.size() - rd_base), 32'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && rd_base + i < rdreq_q.size(); i++)
            check($sformatf("%s_pop%0d", tag, i), 32'(rdreq_q[rd_base + i]), 32'(exp_rd[i]));
        check($sformatf("%s_gap", tag), 32'(gap_bad), 32'd0);
        check($sformatf("%s_hold", tag), 32'(hold_bad), 32'd0);
        check($sformatf("%s_rdreq", tag), 32'(rdreq_bad), 32'd0);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(bus.grant_bus), 32'd0);
        check("rst_rdreq", 32'(bus.rdreq_bus), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        #2 n_rst = 1'b1;
        model_ptr = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] have;
        int n;
        bus.enable = 1'b0; bus.have_msg_bus = '0; bus.tx_ready = 1'b1;
        for (int a = 0; a < N; a++) begin
            len_tab[a] = $urandom_range(5);
            for (int k = 0; k < 16; k++) mem[a][k] = 8'($urandom);
        end

        // Single request on addr 3, grant latency and grant duration
        do_reset();
        start_test();
        len_tab[3] = 1; mem[3][0] = 8'h0A;
        stop_after = 1; watch_grant = N'(1) << 3; grant_cycles = 0;
        model_serve(N'(1) << 3, 1);
        bus.have_msg_bus = N'(1) << 3; bus.enable = 1'b1;
        step();
        check("single_grant_lat", 32'(bus.grant_bus), 32'(N'(1) << 3));
        check("single_valid_lat", 32'(bus.tx_valid), 32'd1);
        check("single_sync", 32'(bus.tx_data), 32'h55);
        run("single", 100);
        compare("single");
        check("single_grant_cycles", 32'(grant_cycles), 32'd5);
        check("single_grant_off", 32'(bus.grant_bus), 32'd0);
        bus.have_msg_bus = '0; watch_grant = '1;

        // Round robin between addr 0 and 24 from a fresh pointer
        do_reset();
        start_test();
        len_tab[0] = 1; len_tab[24] = 1;
        have = (N'(1) << 0) | (N'(1) << 24);
        model_serve(have, 4);
        stop_after = 4; bus.have_msg_bus = have; bus.enable = 1'b1;
        run("rr", 200);
        compare("rr");

        // Randomized masks, lengths and backpressure
        rand_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            start_test();
            have = N'($urandom) | (N'(1) << $urandom_range(N - 1));
            for (int a = 0; a < N; a++) len_tab[a] = $urandom_range(5);
            model_serve(have, 6);
            stop_after = 6; bus.have_msg_bus = have; bus.enable = 1'b1;
            run($sformatf("rand%0d", r), 3000);
            compare($sformatf("rand%0d", r));
        end
        rand_ready = 1'b0; bus.tx_ready = 1'b1; bus.have_msg_bus = '0;

        // Backpressure during DATA, with len changing after capture
        start_test();
        len_tab[5] = 2; mem[5][0] = 8'hA5; mem[5][1] = 8'h3C; len_glitch = 1'b1;
        model_serve(N'(1) << 5, 1);
        stop_after = 1; bus.have_msg_bus = N'(1) << 5; bus.enable = 1'b1;
        n = 0;
        while (rx_q.size() - rx_base < 3 && n < 20) begin step(); n++; end
        check("bp_reach_data", 32'(n < 20), 32'd1);
        bus.tx_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp_hold_valid%0d", c), 32'(bus.tx_valid), 32'd1);
            check($sformatf("bp_hold_data%0d", c), 32'(bus.tx_data), 32'hA5);
            step();
        end
        check("bp_no_pop_stalled", 32'(rdreq_q.size() - rd_base), 32'd0);
        bus.tx_ready = 1'b1;
        run("bp", 50);
        compare("bp");
        check("bp_chk", 32'(rx_q[$]), 32'h9E);
        len_glitch = 1'b0; bus.have_msg_bus = '0;

        // Zero length on addr 1
        start_test();
        len_tab[1] = 0;
        model_serve(N'(1) << 1, 1);
        stop_after = 1; bus.have_msg_bus = N'(1) << 1; bus.enable = 1'b1;
        run("zero", 50);
        compare("zero");
        bus.have_msg_bus = '0;

        // Addr 27 wraps the pointer; enable dropped mid-packet holds off the next grant
        start_test();
        len_tab[27] = $urandom_range(1, 4);
        bus.have_msg_bus = N'(1) << 27; bus.enable = 1'b1;
        n = 0;
        while (bus.grant_bus == 0 && n < 20) begin step(); n++; end
        check("wrap_grant27", 32'(bus.grant_bus), 32'(N'(1) << 27));
        have = (N'(1) << 27) | N'(1);
        bus.have_msg_bus = have; bus.enable = 1'b0;
        model_pkt(27);
        run("wrap", 100);
        repeat (5) step();
        check("wrap_no_grant", 32'(grants), 32'd1);
        check("wrap_idle", 32'(bus.busy), 32'd0);
        stop_after = 2; bus.enable = 1'b1;
        model_serve(have, 1);
        run("wrap2", 100);
        compare("wrap");

        // Asynchronous reset in the middle of DATA
        start_test();
        len_tab[2] = 4; len_tab[0] = 2;
        have = (N'(1) << 0) | (N'(1) << 2);
        bus.have_msg_bus = have; bus.enable = 1'b1;
        n = 0;
        while (rx_q.size() - rx_base < 4 && n < 50) begin step(); n++; end
        check("arst_pre_grant", 32'(bus.grant_bus), 32'(N'(1) << rr_pick(have, model_ptr)));
        check("arst_pre_busy", 32'(bus.busy), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        check("arst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("arst_grant", 32'(bus.grant_bus), 32'd0);
        check("arst_rdreq", 32'(bus.rdreq_bus), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #3 n_rst = 1'b1;
        model_ptr = 0;
        start_test();
        stop_after = 1;
        model_serve(have, 1);
        run("arst", 100);
        compare("arst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
